// File: rtl/seq_cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, running
// decision encoding and the decision-to-flag helper.
package seq_cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        DEC_EQ = 2'd0,
        DEC_GT = 2'd1,
        DEC_LT = 2'd2
    } dec_e;

    // Returns the result flags packed as {eq, gt, lt}; exactly one bit is set.
    function automatic logic [2:0] dec_onehot(input dec_e d);
        logic [2:0] w_flags;
        w_flags = 3'b100;
        case (d)
            DEC_GT:  w_flags = 3'b010;
            DEC_LT:  w_flags = 3'b001;
            default: w_flags = 3'b100;
        endcase
        return w_flags;
    endfunction

endpackage

// File: rtl/seq_mag_comparator_cmp_chunk.sv
// Combinational CHUNK-bit unsigned compare used for one slice per clock.
module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             c_eq,
    output logic             c_gt
);

    assign c_eq = (a == b);
    assign c_gt = (a > b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle unsigned magnitude comparator, scanning MSB-first CHUNK bits per clock.
// Optional build macro SEQ_CMP_EARLY_EXIT_EN finishes on the first differing chunk.
module seq_mag_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output state_e           dbg_state
);

    // Handshake: start is a request honoured only on an edge where busy==0; done is a
    // single-cycle result strobe and coincides with busy==0, so a held start chains compares.

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_e           r_state;
    state_e           w_state_nx;
    dec_e             r_dec;
    dec_e             w_dec_nx;
    dec_e             w_dec_now;
    logic [IDXW-1:0]  r_idx;
    logic [IDXW-1:0]  w_idx_nx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_res;
    logic [2:0]       w_res_nx;
    logic             r_done;
    logic             w_done_nx;
    logic             w_load;
    logic             w_last;
    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic             w_c_eq;
    logic             w_c_gt;

    assign w_a_slice = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_slice = r_b[r_idx*CHUNK +: CHUNK];

    cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .c_eq (w_c_eq),
        .c_gt (w_c_gt)
    );

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_dec_nx   = r_dec;
        w_res_nx   = r_res;
        w_done_nx  = 1'b0;
        w_load     = 1'b0;
        w_dec_now  = r_dec;
        w_last     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_idx_nx   = LAST_IDX;
                    w_dec_nx   = DEC_EQ;
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                // Only the most significant differing chunk may set the decision.
                if (r_dec == DEC_EQ && !w_c_eq) begin
                    w_dec_now = w_c_gt ? DEC_GT : DEC_LT;
                end
                w_dec_nx = w_dec_now;
`ifdef SEQ_CMP_EARLY_EXIT_EN
                w_last = (r_idx == '0) || (w_dec_now != DEC_EQ);
`else
                w_last = (r_idx == '0);
`endif
                if (w_last) begin
                    w_state_nx = IDLE;
                    w_done_nx  = 1'b1;
                    w_res_nx   = dec_onehot(w_dec_now);
                end else begin
                    w_idx_nx = r_idx - 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dec   <= DEC_EQ;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= 3'b000;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_dec   <= w_dec_nx;
            r_idx   <= w_idx_nx;
            r_res   <= w_res_nx;
            r_done  <= w_done_nx;
            if (w_load) begin
                r_a <= A;
                r_b <= B;
            end
        end
    end

    assign busy      = (r_state == RUN);
    assign done      = r_done;
    assign eq        = r_res[2];
    assign gt        = r_res[1];
    assign lt        = r_res[0];
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed-vector bench for seq_mag_comparator (WIDTH=16, CHUNK=4) with a result/latency scoreboard.
module tb_seq_mag_comparator;
  import seq_cmp_pkg::*;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic        eq;
  logic        gt;
  logic        lt;
  state_e      dbg_state;

  logic [2:0]  exp_q[$];
  int          exp_cyc_q[$];
  logic [2:0]  last_res = 3'b000;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  seq_mag_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [2:0] r;
    int         c;
    if (rst_n === 1'b1) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no pending compare (cycle %0d)", cyc);
        end else begin
          r = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("result_eq_gt_lt", {29'd0, eq, gt, lt}, {29'd0, r});
          check("done_cycle", cyc, c);
          check("busy_low_at_done", {31'd0, busy}, 32'd0);
          last_res = r;
        end
      end else begin
        check("held_result", {29'd0, eq, gt, lt}, {29'd0, last_res});
        check("busy_while_pending", {31'd0, busy}, {31'd0, exp_q.size() != 0});
      end
    end
  end

  // driver tasks: called at a negedge, return at a negedge
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] res,
                       input int lat_full, input int lat_early);
    int lat;
    int n;
    lat = lat_full;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    lat = lat_early;
`endif
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      n_vec++;
      n_fail++;
      $display("FAIL issue_wait: busy stuck high, expected idle within 60 cycles");
    end
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(res);
    exp_cyc_q.push_back(cyc + lat);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    start = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_idle: no done within 60 cycles, %0d compares pending", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_flags"}, {29'd0, eq, gt, lt}, 32'd0);
    check({tag, "_state"}, {31'd0, dbg_state}, {31'd0, IDLE});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h0000, 16'h0000, R_EQ, 4, 4); wait_idle();
    issue(16'hA5A5, 16'hA5A4, R_GT, 4, 4); wait_idle();
    issue(16'h1FFF, 16'h2000, R_LT, 4, 1); wait_idle();
    issue(16'hFFFF, 16'hFFFE, R_GT, 4, 4); wait_idle();
    issue(16'h7000, 16'h7100, R_LT, 4, 2); wait_idle();

    // start pulsed mid-compare with different operands must be ignored
    issue(16'h00F0, 16'h00E0, R_GT, 4, 3);
    start = 1'b0;
    @(negedge clk);
    A = 16'h0000;
    B = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // asynchronous reset at edge 2 of a compare: abort, no done afterwards
    issue(16'h1234, 16'h1235, R_LT, 4, 4);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    last_res = 3'b000;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(16'hFFFF, 16'h0001, R_GT, 4, 1); wait_idle();

    // back-to-back: start held high across each done
    issue(16'h8000, 16'h8000, R_EQ, 4, 4);
    issue(16'h0010, 16'h0020, R_LT, 4, 3);
    issue(16'hBEEF, 16'hBEEF, R_EQ, 4, 4);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
